// File: rtl/typing_pkg.sv
// Shared constants, key-kind codes and FSM state type for the typing engine.
package typing_pkg;

   localparam int unsigned CHAR_W   = 5;
   localparam int unsigned MAX_LEN  = 25;
   localparam int unsigned WORD_MAX = 15;
   localparam int unsigned TOT_W    = 5;
   localparam int unsigned WORDS_W  = 10;
   localparam int unsigned CHARS_W  = 14;
   localparam int unsigned ERRS_W   = 10;

   localparam logic [1:0] KEY_LETTER = 2'd0;
   localparam logic [1:0] KEY_SPACE  = 2'd1;
   localparam logic [1:0] KEY_BACK   = 2'd2;

   localparam logic [CHAR_W-1:0] CHAR_BLANK = '0;
   localparam logic [CHAR_W-1:0] CHAR_LAST  = 5'd26;
   localparam logic [TOT_W-1:0]  TOT_FULL   = 5'd25;

   typedef enum logic [1:0] {StIdle, StTyping, StAdvance} state_e;

   function automatic logic is_letter(logic [CHAR_W-1:0] c);
      return (c != CHAR_BLANK) && (c <= CHAR_LAST);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and a variable increment amount.
module sat_counter #(
   parameter int unsigned Width = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clr_i,
   input  logic [Width-1:0] amt_i,
   output logic [Width-1:0] count_o
);

   logic [Width-1:0] cnt_q, cnt_d;
   logic [Width:0]   sum;

   always_comb begin
      sum = {1'b0, cnt_q} + {1'b0, amt_i};
      if (clr_i) begin
         cnt_d = '0;
      end else if (sum[Width]) begin
         cnt_d = '1;
      end else begin
         cnt_d = sum[Width-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;

endmodule

// File: rtl/typing_engine.sv
// Keystroke engine: maintains the typed buffer, matching prefix and round statistics
// for the renderer and WPM/accuracy logic.
module typing_engine
   import typing_pkg::*;
(
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        game_en_i,
   input  logic                        key_valid_i,
   output logic                        key_ready_o,
   input  logic [1:0]                  key_kind_i,
   input  logic [CHAR_W-1:0]           key_code_i,
   input  logic [WORD_MAX*CHAR_W-1:0]  target_word_i,
   input  logic [TOT_W-1:0]            target_len_i,
   output logic [MAX_LEN*CHAR_W-1:0]   type_o,
   output logic [TOT_W-1:0]            tot_o,
   output logic [TOT_W-1:0]            correct_o,
   output logic                        next_word_o,
   output logic [WORDS_W-1:0]          words_done_o,
   output logic [CHARS_W-1:0]          chars_ok_o,
   output logic [ERRS_W-1:0]           errors_o
);

   state_e                      state_q, state_d;
   logic [MAX_LEN*CHAR_W-1:0]   type_q, type_d;
   logic [TOT_W-1:0]            tot_q, tot_d;
   logic [TOT_W-1:0]            correct_q, correct_d;
   logic                        next_word_q, next_word_d;
   logic                        key_ready;
   logic                        cnt_clr;
   logic [WORDS_W-1:0]          words_amt;
   logic [CHARS_W-1:0]          chars_amt;
   logic [ERRS_W-1:0]           errs_amt;
   logic [CHAR_W-1:0]           tgt_char;
   logic [TOT_W-1:0]            tot_m1;

   always_comb begin
      tgt_char = CHAR_BLANK;
      for (int unsigned i = 0; i < WORD_MAX; i++) begin
         if (TOT_W'(i) == tot_q) tgt_char = target_word_i[i*CHAR_W +: CHAR_W];
      end
   end

   assign tot_m1 = tot_q - 1'b1;

   always_comb begin
      state_d     = state_q;
      type_d      = type_q;
      tot_d       = tot_q;
      correct_d   = correct_q;
      next_word_d = 1'b0;
      key_ready   = 1'b0;
      cnt_clr     = 1'b0;
      words_amt   = '0;
      chars_amt   = '0;
      errs_amt    = '0;

      if (!game_en_i) begin
         // Counters hold for the results screen; only the buffer is wiped.
         state_d   = StIdle;
         type_d    = '0;
         tot_d     = '0;
         correct_d = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               type_d    = '0;
               tot_d     = '0;
               correct_d = '0;
               cnt_clr   = 1'b1;
               state_d   = StTyping;
            end
            StAdvance: state_d = StTyping;
            StTyping: begin
               key_ready = 1'b1;
               if (key_valid_i) begin
                  case (key_kind_i)
                     KEY_LETTER: begin
                        if (is_letter(key_code_i)) begin
                           if (tot_q == TOT_FULL) begin
                              errs_amt = ERRS_W'(1);
                           end else begin
                              for (int unsigned i = 0; i < MAX_LEN; i++) begin
                                 if (TOT_W'(i) == tot_q) type_d[i*CHAR_W +: CHAR_W] = key_code_i;
                              end
                              tot_d = tot_q + 1'b1;
                              if (correct_q == tot_q && tot_q < target_len_i &&
                                  key_code_i == tgt_char) begin
                                 correct_d = correct_q + 1'b1;
                              end else begin
                                 errs_amt = ERRS_W'(1);
                              end
                           end
                        end
                     end
                     KEY_SPACE: begin
                        if (tot_q == target_len_i && correct_q == target_len_i) begin
                           type_d      = '0;
                           tot_d       = '0;
                           correct_d   = '0;
                           words_amt   = WORDS_W'(1);
                           chars_amt   = CHARS_W'(target_len_i) + CHARS_W'(1);
                           next_word_d = 1'b1;
                           state_d     = StAdvance;
                        end else begin
                           errs_amt = ERRS_W'(1);
                        end
                     end
                     KEY_BACK: begin
                        if (tot_q != '0) begin
                           for (int unsigned i = 0; i < MAX_LEN; i++) begin
                              if (TOT_W'(i) == tot_m1) type_d[i*CHAR_W +: CHAR_W] = CHAR_BLANK;
                           end
                           tot_d = tot_m1;
                           if (correct_q == tot_q) correct_d = correct_q - 1'b1;
                        end
                     end
                     default: ;
                  endcase
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StIdle;
         type_q      <= '0;
         tot_q       <= '0;
         correct_q   <= '0;
         next_word_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         type_q      <= type_d;
         tot_q       <= tot_d;
         correct_q   <= correct_d;
         next_word_q <= next_word_d;
      end
   end

   sat_counter #(.Width(WORDS_W)) u_words (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cnt_clr),
      .amt_i   (words_amt),
      .count_o (words_done_o)
   );

   sat_counter #(.Width(CHARS_W)) u_chars (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cnt_clr),
      .amt_i   (chars_amt),
      .count_o (chars_ok_o)
   );

   sat_counter #(.Width(ERRS_W)) u_errs (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .clr_i   (cnt_clr),
      .amt_i   (errs_amt),
      .count_o (errors_o)
   );

   assign key_ready_o = key_ready;
   assign type_o      = type_q;
   assign tot_o       = tot_q;
   assign correct_o   = correct_q;
   assign next_word_o = next_word_q;

endmodule

// File: tb/tb_typing_engine.sv
// Bench for typing_engine: directed plan with literal checks, then random keystrokes
// compared every cycle against a buffer/queue model of the typing rules.
module tb_typing_engine;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         game_en = 1'b0;
   logic         key_valid = 1'b0;
   logic         key_ready;
   logic [1:0]   key_kind = 2'd3;
   logic [4:0]   key_code = 5'd0;
   logic [74:0]  target_word = '0;
   logic [4:0]   target_len = 5'd1;
   logic [124:0] dut_type;
   logic [4:0]   tot, correct;
   logic         next_word;
   logic [9:0]   words_done, errors;
   logic [13:0]  chars_ok;

   typing_engine dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .game_en_i     (game_en),
      .key_valid_i   (key_valid),
      .key_ready_o   (key_ready),
      .key_kind_i    (key_kind),
      .key_code_i    (key_code),
      .target_word_i (target_word),
      .target_len_i  (target_len),
      .type_o        (dut_type),
      .tot_o         (tot),
      .correct_o     (correct),
      .next_word_o   (next_word),
      .words_done_o  (words_done),
      .chars_ok_o    (chars_ok),
      .errors_o      (errors)
   );

   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   // Reference model: the buffer is a queue, correct is the common prefix length.
   int tgt [15];
   int tlen = 1;
   int mbuf[$];
   int mstate = 0;  // 0 idle, 1 typing, 2 advance
   bit mnext = 1'b0;
   int mwords = 0, mchars = 0, merrs = 0;

   function automatic int sat(int v, int mx);
      return (v > mx) ? mx : v;
   endfunction

   function automatic int mcorrect();
      int n = 0;
      while (n < mbuf.size() && n < tlen && mbuf[n] == tgt[n]) n++;
      return n;
   endfunction

   function automatic logic [124:0] mtype();
      logic [124:0] v = '0;
      for (int i = 0; i < mbuf.size(); i++) v[i*5 +: 5] = 5'(mbuf[i]);
      return v;
   endfunction

   task automatic mstep();
      int c0;
      mnext = 1'b0;
      if (!game_en) begin
         mbuf.delete();
         mstate = 0;
      end else if (mstate == 0) begin
         mbuf.delete();
         mwords = 0; mchars = 0; merrs = 0;
         mstate = 1;
      end else if (mstate == 2) begin
         mstate = 1;
      end else if (key_valid) begin
         case (key_kind)
            2'd0: if (key_code >= 1 && key_code <= 26) begin
               if (mbuf.size() == 25) begin
                  merrs = sat(merrs + 1, 1023);
               end else begin
                  c0 = mcorrect();
                  mbuf.push_back(int'(key_code));
                  if (mcorrect() == c0) merrs = sat(merrs + 1, 1023);
               end
            end
            2'd1: if (mbuf.size() == tlen && mcorrect() == tlen) begin
               mbuf.delete();
               mwords = sat(mwords + 1, 1023);
               mchars = sat(mchars + tlen + 1, 16383);
               mnext  = 1'b1;
               mstate = 2;
            end else begin
               merrs = sat(merrs + 1, 1023);
            end
            2'd2: if (mbuf.size() > 0) void'(mbuf.pop_back());
            default: ;
         endcase
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mbuf.delete();
         mstate = 0; mnext = 1'b0;
         mwords = 0; mchars = 0; merrs = 0;
      end else begin
         mstep();
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("key_ready", 128'(key_ready), 128'(mstate == 1 && game_en));
         chk("type", 128'(dut_type), 128'(mtype()));
         chk("tot", 128'(tot), 128'(mbuf.size()));
         chk("correct", 128'(correct), 128'(mcorrect()));
         chk("next_word", 128'(next_word), 128'(mnext));
         chk("words_done", 128'(words_done), 128'(mwords));
         chk("chars_ok", 128'(chars_ok), 128'(mchars));
         chk("errors", 128'(errors), 128'(merrs));
      end
   end

   task automatic set_target(input int len);
      target_len  = 5'(len);
      tlen        = len;
      target_word = '0;
      for (int i = 0; i < 15; i++) begin
         target_word[i*5 +: 5] = 5'(tgt[i]);
      end
   endtask

   task automatic set_cat();
      for (int i = 0; i < 15; i++) tgt[i] = 0;
      tgt[0] = 3; tgt[1] = 1; tgt[2] = 20;
      set_target(3);
   endtask

   task automatic idle_cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one key for a single clock; called and returns at posedge+1.
   task automatic key(input int kind, input int code);
      key_valid = 1'b1;
      key_kind  = 2'(kind);
      key_code  = 5'(code);
      idle_cyc(1);
      key_valid = 1'b0;
   endtask

   initial begin
      int r, code;
      set_cat();
      idle_cyc(2);
      chk_en = 1'b1;
      chk("rst_tot", 128'(tot), 128'(0));
      chk("rst_key_ready", 128'(key_ready), 128'(0));
      rst_n = 1'b1;
      game_en = 1'b1;
      idle_cyc(1);
      chk("start_ready", 128'(key_ready), 128'(1));

      // Complete "cat"
      key(0, 3); key(0, 1); key(0, 20);
      chk("cat_tot", 128'(tot), 128'(3));
      chk("cat_correct", 128'(correct), 128'(3));
      key(1, 0);
      chk("cat_next_word", 128'(next_word), 128'(1));
      chk("cat_type", 128'(dut_type), 128'(0));
      chk("cat_words", 128'(words_done), 128'(1));
      chk("cat_chars", 128'(chars_ok), 128'(4));
      chk("adv_ready", 128'(key_ready), 128'(0));
      idle_cyc(1);
      chk("adv_pulse_end", 128'(next_word), 128'(0));
      chk("adv_ready_back", 128'(key_ready), 128'(1));

      // Mistype, backspace, fix
      key(0, 3); key(0, 15);
      chk("co_tot", 128'(tot), 128'(2));
      chk("co_correct", 128'(correct), 128'(1));
      chk("co_errors", 128'(errors), 128'(1));
      key(2, 0);
      chk("bs_tot", 128'(tot), 128'(1));
      chk("bs_correct", 128'(correct), 128'(1));
      key(0, 1);
      chk("ca_correct", 128'(correct), 128'(2));

      // Premature space
      key(1, 0);
      chk("early_space_err", 128'(errors), 128'(2));
      chk("early_space_tot", 128'(tot), 128'(2));
      chk("early_space_nw", 128'(next_word), 128'(0));
      key(2, 0); key(2, 0);

      // Overflow: 25 mismatching letters + one dropped = 26 more errors
      for (int i = 0; i < 26; i++) key(0, (i % 26) + 1);
      chk("full_tot", 128'(tot), 128'(25));
      chk("full_slot24", 128'(dut_type[120 +: 5]), 128'(25));
      chk("full_errors", 128'(errors), 128'(28));
      for (int i = 0; i < 23; i++) key(2, 0);

      // Drop game_en with tot = 2; a space in that cycle must not count
      game_en = 1'b0;
      key(1, 0);
      chk("drop_tot", 128'(tot), 128'(0));
      chk("drop_type", 128'(dut_type), 128'(0));
      chk("drop_errors", 128'(errors), 128'(28));
      chk("drop_words", 128'(words_done), 128'(1));
      game_en = 1'b1;
      idle_cyc(1);
      chk("restart_errors", 128'(errors), 128'(0));
      chk("restart_chars", 128'(chars_ok), 128'(0));

      // Ignored keys
      key(2, 0); key(3, 5); key(0, 0); key(0, 27);
      chk("ignored_tot", 128'(tot), 128'(0));
      chk("ignored_errors", 128'(errors), 128'(0));

      // Async reset mid-word
      key(1, 0); key(0, 3); key(0, 1);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_tot", 128'(tot), 128'(0));
      chk("arst_correct", 128'(correct), 128'(0));
      chk("arst_errors", 128'(errors), 128'(0));
      chk("arst_type", 128'(dut_type), 128'(0));
      #1 rst_n = 1'b1;
      idle_cyc(2);

      // Random round
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (mnext) begin
            r = $urandom_range(1, 15);
            for (int i = 0; i < 15; i++) tgt[i] = (i < r) ? int'($urandom_range(1, 26)) : 0;
            set_target(r);
         end
         game_en   = ($urandom_range(0, 299) != 0);
         key_valid = ($urandom_range(0, 9) < 7);
         r = $urandom_range(0, 99);
         if (mcorrect() < mbuf.size() && r < 40) begin
            key_kind = 2'd2; key_code = 5'($urandom_range(0, 31));
         end else if (r < 60) begin
            if ($urandom_range(0, 3) != 0 && mbuf.size() < tlen) code = tgt[mbuf.size()];
            else code = $urandom_range(0, 31);
            key_kind = 2'd0; key_code = 5'(code);
         end else if (r < 80) begin
            key_kind = 2'd1; key_code = 5'($urandom_range(0, 31));
         end else if (r < 93) begin
            key_kind = 2'd2; key_code = 5'($urandom_range(0, 31));
         end else begin
            key_kind = 2'd3; key_code = 5'($urandom_range(0, 31));
         end
         idle_cyc(1);
      end

      // Error counter saturation
      key_valid = 1'b0;
      game_en = 1'b0;
      idle_cyc(1);
      game_en = 1'b1;
      set_cat();
      idle_cyc(1);
      key_valid = 1'b1; key_kind = 2'd1; key_code = 5'd0;
      idle_cyc(1030);
      key_valid = 1'b0;
      chk("errors_saturate", 128'(errors), 128'(1023));
      idle_cyc(2);

      chk_en = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
